irq_source_arbiter: RTL and testbench

- Upstream stage of the interrupt controller; collects N_SRC external interrupt lines and presents one request at a time.
- Synchronizes and edge/level-qualifies each line, holds per-source pending bits, and picks the highest-priority enabled pending source.
- Drives the controller's irq_req_i with its request output and supplies the matching mcause value.
- Consumes the controller's irq_o as the acknowledge and irq_ret_o as end-of-service.

---
 rtl/irq_source_arbiter.sv | 162 ++++++++++++++++
 tb/tb_irq_source_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_source_arbiter.sv
// Interrupt source arbiter: synchronizes, edge/level-qualifies and prioritizes N_SRC lines
// and hands one request at a time to the interrupt controller. Macro: IRQ_SRC_SYNC_EN.
module irq_source_arbiter #(
   parameter int          N_SRC       = 16,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] CAUSE_BASE  = 32'h8000_0010
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [N_SRC-1:0]         irq_src_i,
   input  logic [N_SRC-1:0]         irq_en_i,
   input  logic [N_SRC-1:0]         irq_edge_i,
   input  logic                     irq_ack_i,
   input  logic                     irq_ret_i,
   output logic                     irq_req_o,
   output logic [$clog2(N_SRC)-1:0] irq_id_o,
   output logic [31:0]              irq_cause_o,
   output logic                     irq_busy_o
);

   localparam int ID_W = $clog2(N_SRC);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               req_q, req_d;
   logic               busy_q, busy_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [N_SRC-1:0]   pend_q, pend_d;
   logic [N_SRC-1:0]   prev_q;
   logic [N_SRC-1:0]   sync_s;
   logic [N_SRC-1:0]   masked_s;
   logic [N_SRC-1:0]   ack_clr_s;
   logic               ack_take_s;
   logic               cand_vld_s;
   logic [ID_W-1:0]    cand_id_s;

   // Without a real synchronizer the stage count has no effect; this only keeps it referenced.
   if (SYNC_STAGES < 1) begin : g_sync_stages_invalid
   end

`ifdef IRQ_SRC_SYNC_EN
   logic [N_SRC-1:0] sync_q [SYNC_STAGES];

   // Multi-flop synchronizer chain for the raw asynchronous lines.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= irq_src_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];
`else
   assign sync_s = irq_src_i;
`endif

   assign masked_s  = pend_q & irq_en_i;
   assign ack_clr_s = ack_take_s ? ({{(N_SRC-1){1'b0}}, 1'b1} << id_q) : {N_SRC{1'b0}};

   // Fixed-priority pick: lowest enabled pending index wins.
   always_comb begin
      cand_vld_s = |masked_s;
      cand_id_s  = {ID_W{1'b0}};
      for (int k = N_SRC - 1; k >= 0; k--) begin
         cand_id_s = masked_s[k] ? ID_W'(k) : cand_id_s;
      end
   end

   // Pending update; a new edge beats a simultaneous acknowledge clear.
   always_comb begin
      pend_d = pend_q;
      for (int k = 0; k < N_SRC; k++) begin
         if (irq_edge_i[k]) begin
            pend_d[k] = (sync_s[k] & ~prev_q[k]) | (pend_q[k] & ~ack_clr_s[k]);
         end else begin
            pend_d[k] = sync_s[k];
         end
      end
   end

   // Request/service FSM; id is frozen outside IDLE so arbitration is non-preemptive.
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      busy_d     = busy_q;
      id_d       = id_q;
      ack_take_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (cand_vld_s) begin
               state_d = REQ;
               req_d   = 1'b1;
               id_d    = cand_id_s;
            end else begin
               req_d   = 1'b0;
            end
         end
         REQ: begin
            if (irq_ack_i) begin
               state_d    = SERVICE;
               req_d      = 1'b0;
               busy_d     = 1'b1;
               ack_take_s = 1'b1;
            end else if (!masked_s[id_q]) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end else begin
               req_d   = 1'b1;
            end
         end
         SERVICE: begin
            if (irq_ret_i) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, pending, edge history and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         id_q    <= {ID_W{1'b0}};
         pend_q  <= {N_SRC{1'b0}};
         prev_q  <= {N_SRC{1'b0}};
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         id_q    <= id_d;
         pend_q  <= pend_d;
         prev_q  <= sync_s;
      end
   end

   assign irq_req_o   = req_q;
   assign irq_busy_o  = busy_q;
   assign irq_id_o    = id_q;
   assign irq_cause_o = CAUSE_BASE + {{(32-ID_W){1'b0}}, id_q};

endmodule

// File: tb/tb_irq_source_arbiter.sv
// Directed self-checking bench for irq_source_arbiter (default parameters).
module tb_irq_source_arbiter;

   localparam int N = 16;
`ifdef IRQ_SRC_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  src = '0;
   logic [N-1:0]  en = '1;
   logic [N-1:0]  edge_m = 16'hFFFD;
   logic          ack = 1'b0;
   logic          ret = 1'b0;
   logic          req;
   logic [3:0]    id;
   logic [31:0]   cause;
   logic          busy;
   int            tests = 0;
   int            fails = 0;

   irq_source_arbiter dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .irq_src_i   (src),
      .irq_en_i    (en),
      .irq_edge_i  (edge_m),
      .irq_ack_i   (ack),
      .irq_ret_i   (ret),
      .irq_req_o   (req),
      .irq_id_o    (id),
      .irq_cause_o (cause),
      .irq_busy_o  (busy)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_req(input string tag, input logic r, input logic [3:0] i);
      chk({tag, "_req"}, {31'd0, req}, {31'd0, r});
      if (r) begin
         chk({tag, "_id"}, {28'd0, id}, {28'd0, i});
         chk({tag, "_cause"}, cause, 32'h8000_0010 + {28'd0, i});
      end else begin
         chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      end
   endtask

   task automatic do_ack;
      ack = 1'b1;
      step(1);
      ack = 1'b0;
   endtask

   task automatic do_ret;
      ret = 1'b1;
      step(1);
      ret = 1'b0;
   endtask

   initial begin
      // reset values
      step(2);
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_id", {28'd0, id}, 32'd0);
      chk("rst_cause", cause, 32'h8000_0010);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      step(2);

      // single edge on src5
      src[5] = 1'b1;
      step(LAT - 1);
      chk_req("e5_early", 1'b0, 4'd0);
      step(1);
      chk_req("e5", 1'b1, 4'd5);
      src[5] = 1'b0;
      do_ack();
      chk("e5_ack_req", {31'd0, req}, 32'd0);
      chk("e5_ack_busy", {31'd0, busy}, 32'd1);
      do_ret();
      chk("e5_ret_busy", {31'd0, busy}, 32'd0);
      step(LAT + 2);
      chk_req("e5_norereq", 1'b0, 4'd0);

      // priority and non-preemption
      src[7] = 1'b1;
      src[2] = 1'b1;
      step(LAT);
      chk_req("pri2", 1'b1, 4'd2);
      src[7] = 1'b0;
      src[2] = 1'b0;
      do_ack();
      src[0] = 1'b1;
      step(1);
      src[0] = 1'b0;
      step(LAT + 1);
      chk("np_req", {31'd0, req}, 32'd0);
      chk("np_id", {28'd0, id}, 32'd2);
      chk("np_busy", {31'd0, busy}, 32'd1);
      do_ret();
      chk_req("np_ret", 1'b0, 4'd0);
      step(1);
      chk_req("pri0", 1'b1, 4'd0);
      do_ack();
      do_ret();
      step(1);
      chk_req("pri7", 1'b1, 4'd7);
      do_ack();
      do_ret();
      step(LAT + 2);
      chk_req("pri_drain", 1'b0, 4'd0);

      // level source re-request
      src[1] = 1'b1;
      step(LAT);
      chk_req("lvl1", 1'b1, 4'd1);
      do_ack();
      chk("lvl_busy", {31'd0, busy}, 32'd1);
      do_ret();
      chk_req("lvl_gap1", 1'b0, 4'd0);
      step(1);
      chk_req("lvl_rereq", 1'b1, 4'd1);
      do_ack();
      src[1] = 1'b0;
      step(LAT);
      do_ret();
      step(1);
      chk_req("lvl_drop", 1'b0, 4'd0);
      step(LAT);
      chk_req("lvl_drop2", 1'b0, 4'd0);

      // withdrawal by mask, then re-enable
      src[4] = 1'b1;
      step(1);
      src[4] = 1'b0;
      step(LAT - 1);
      chk_req("w4", 1'b1, 4'd4);
      en[4] = 1'b0;
      step(1);
      chk_req("w4_withdrawn", 1'b0, 4'd0);
      step(2);
      chk_req("w4_masked", 1'b0, 4'd0);
      en[4] = 1'b1;
      step(1);
      chk_req("w4_reen", 1'b1, 4'd4);
      do_ack();
      do_ret();
      step(LAT + 2);
      chk_req("w4_drain", 1'b0, 4'd0);

      // new edge coinciding with the acknowledge of the same source
      src[6] = 1'b1;
      step(1);
      src[6] = 1'b0;
      step(LAT - 1);
      chk_req("c6", 1'b1, 4'd6);
      src[6] = 1'b1;
      step(LAT - 2);
      do_ack();
      src[6] = 1'b0;
      chk("c6_busy", {31'd0, busy}, 32'd1);
      do_ret();
      step(1);
      chk_req("c6_again", 1'b1, 4'd6);
      do_ack();
      do_ret();
      step(LAT + 2);
      chk_req("c6_drain", 1'b0, 4'd0);

      // asynchronous reset in the middle of a request
      src[3] = 1'b1;
      step(1);
      src[3] = 1'b0;
      step(LAT - 1);
      chk_req("r3", 1'b1, 4'd3);
      rst_n = 1'b0;
      #1;
      chk("arst_req", {31'd0, req}, 32'd0);
      chk("arst_id", {28'd0, id}, 32'd0);
      chk("arst_cause", cause, 32'h8000_0010);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      step(1);
      rst_n = 1'b1;
      step(LAT + 2);
      chk_req("arst_nopend", 1'b0, 4'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
